// File: rtl/membus_pkg.sv
// Shared types for the unified-memory arbiter: in-flight owner tag and request/response bundles.
// Struct widths are fixed to the default bus geometry.
package membus_pkg;

   localparam int MEMBUS_ADDR_W = 16;
   localparam int MEMBUS_DATA_W = 64;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

   typedef struct packed {
      logic                     valid;
      logic                     wen;
      logic [MEMBUS_ADDR_W-1:0] addr;
      logic [MEMBUS_DATA_W-1:0] wdata;
   } membus_req_t;

   typedef struct packed {
      logic                     rvalid;
      logic [MEMBUS_DATA_W-1:0] rdata;
   } membus_resp_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input grant generator, grant is combinational in the request cycle.
// Under contention it alternates (ROUND_ROBIN!=0) or always favours port 1.
module rr_arbiter2 #(
   parameter int ROUND_ROBIN = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic req0_i,
   input  logic req1_i,
   output logic gnt0_o,
   output logic gnt1_o
);

   // last1_q: port 1 won the most recent contention (reset value: port 0 won)
   logic last1_q;
   logic last1_d;

   always_comb begin
      gnt0_o  = 1'b0;
      gnt1_o  = 1'b0;
      last1_d = last1_q;
      if (req0_i && req1_i) begin
         if ((ROUND_ROBIN != 0) && last1_q) begin
            gnt0_o  = 1'b1;
            last1_d = 1'b0;
         end else begin
            gnt1_o  = 1'b1;
            last1_d = 1'b1;
         end
      end else begin
         gnt0_o = req0_i;
         gnt1_o = req1_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         last1_q <= 1'b0;
      end else begin
         last1_q <= last1_d;
      end
   end

endmodule

// File: rtl/membus_arbiter.sv
// Shares the 1-cycle single-port memory between fetch (I) and load/store (D);
// grants in the request cycle and steers the next-cycle response to the owner.
module membus_arbiter
   import membus_pkg::*;
#(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 64,
   parameter int ROUND_ROBIN = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_valid,
   output logic                  i_ready,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic                  i_rvalid,
   output logic [DATA_WIDTH-1:0] i_rdata,
   input  logic                  d_valid,
   output logic                  d_ready,
   input  logic                  d_wen,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_rvalid,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  mem_valid,
   output logic                  mem_wen,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   owner_t tag_q;
   owner_t tag_d;
   logic   gnt_i;
   logic   gnt_d;

   // Port 1 is D so that fixed priority favours the LSU.
   rr_arbiter2 #(
      .ROUND_ROBIN(ROUND_ROBIN)
   ) u_arb (
      .clk    (clk),
      .rst    (rst),
      .req0_i (i_valid),
      .req1_i (d_valid),
      .gnt0_o (gnt_i),
      .gnt1_o (gnt_d)
   );

   assign i_ready = gnt_i;
   assign d_ready = gnt_d;

   always_comb begin
      mem_valid = gnt_i | gnt_d;
      mem_wen   = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      tag_d     = OWN_NONE;
      if (gnt_d) begin
         mem_wen   = d_wen;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
         tag_d     = OWN_D;
      end else if (gnt_i) begin
         mem_addr = i_addr;
         tag_d    = OWN_I;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         tag_q <= OWN_NONE;
      end else begin
         tag_q <= tag_d;
      end
   end

   // Writes also return a response (old word) which the LSU treats as completion.
   assign i_rvalid = mem_rvalid && (tag_q == OWN_I);
   assign d_rvalid = mem_rvalid && (tag_q == OWN_D);
   assign i_rdata  = mem_rdata;
   assign d_rdata  = mem_rdata;

   a_one_ready: assert property (@(posedge clk) !(i_ready && d_ready));
   a_no_orphan: assert property (@(posedge clk) mem_rvalid |-> (tag_q != OWN_NONE));
   a_i_hold:    assert property (@(posedge clk) (rst && i_valid && !i_ready) |=> i_valid);
   a_d_hold:    assert property (@(posedge clk) (rst && d_valid && !d_ready) |=> d_valid);
   a_i_resp:    assert property (@(posedge clk) (rst && i_valid && i_ready) |=> (i_rvalid && !d_rvalid));
   a_d_resp:    assert property (@(posedge clk) (rst && d_valid && d_ready) |=> (d_rvalid && !i_rvalid));

endmodule

// File: doc/membus_arbiter.md
Name: membus_arbiter

Overview:
- Shares the single-port, 1-cycle-latency unified memory between the instruction-fetch requester (I) and the load/store requester (D).
- Each cycle it grants at most one request and drives the memory request port.
- It records which requester owns the in-flight access and routes the returned read data to that requester on the following cycle.
- Sits between the core front-end/LSU and the memory block, which accepts one request per cycle and asserts rvalid exactly one cycle after an accepted request.

Parameters:
- ADDR_WIDTH, 16, memory word-address width.
- DATA_WIDTH, 64, memory word width.
- ROUND_ROBIN, 1, 1 = alternate grant on contention; 0 = fixed priority, D always wins.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- i_valid  in  1  I request valid
- i_ready  out  1  I request accepted this cycle
- i_addr  in  ADDR_WIDTH  I word address
- i_rvalid  out  1  I response valid
- i_rdata  out  DATA_WIDTH  I response data
- d_valid  in  1  D request valid
- d_ready  out  1  D request accepted this cycle
- d_wen  in  1  D write enable
- d_addr  in  ADDR_WIDTH  D word address
- d_wdata  in  DATA_WIDTH  D write data
- d_rvalid  out  1  D response valid
- d_rdata  out  DATA_WIDTH  D response data
- mem_valid  out  1  to memory valid
- mem_wen  out  1  to memory wen
- mem_addr  out  ADDR_WIDTH  to memory addr
- mem_wdata  out  DATA_WIDTH  to memory wdata
- mem_rvalid  in  1  from memory rvalid
- mem_rdata  in  DATA_WIDTH  from memory rdata

Behaviour:
- Registers:
  - tag_q: owner of the in-flight access; values NONE, I, D.
  - last_q: last requester granted under contention; values I, D.
- Reset (rst=0 at posedge): tag_q=NONE, last_q=I.
- Outputs during reset and the cycle after: i_rvalid=0, d_rvalid=0. i_ready, d_ready and mem_valid remain combinational and follow the grant logic.
- Grant logic (combinational, same cycle as the request):
  - Only I valid: grant I.
  - Only D valid: grant D.
  - Both valid, ROUND_ROBIN=1: grant the requester not equal to last_q, so the first contention after reset grants D.
  - Both valid, ROUND_ROBIN=0: grant D.
  - Neither valid: no grant.
- Request handshake:
  - i_ready = grant==I; d_ready = grant==D.
  - A request is accepted when valid and ready are both high.
  - Requesters hold addr, wen and wdata stable while valid is high and ready is low.
- Memory drive:
  - mem_valid = any grant.
  - mem_addr, mem_wen, mem_wdata taken from the granted requester. For an I grant: mem_wen=0, mem_wdata=0.
  - With no grant, mem_addr, mem_wen and mem_wdata are 0.
- Sequential update at posedge, rst=1:
  - tag_q <= granted owner, or NONE if no grant.
  - last_q <= granted owner only when both requesters were valid; otherwise unchanged.
- Response routing (combinational from mem_rvalid and tag_q):
  - i_rvalid = mem_rvalid && tag_q==I.
  - d_rvalid = mem_rvalid && tag_q==D.
  - i_rdata = d_rdata = mem_rdata; data is meaningful only with the corresponding rvalid.
- Latency and throughput:
  - Response arrives exactly 1 cycle after acceptance.
  - Back-to-back grants are allowed every cycle, giving a throughput of one access per cycle.
  - Only one access is in flight at a time, so no queue is needed.
- Writes:
  - D write responses still pulse d_rvalid, with d_rdata carrying the pre-write memory word.
  - The LSU uses this pulse as write completion.
- Boundary cases:
  - mem_rvalid while tag_q==NONE: no rvalid is forwarded; assertion error in simulation.
  - Reset during an in-flight access: tag_q is cleared and the pending response is dropped. Memory also clears its rvalid, so no stale response appears.
  - A requester deasserting valid before ready is a protocol violation; assertion error in simulation.
- Simulation assertions:
  - i_ready and d_ready are never high together.
  - Every accepted request is followed by exactly one rvalid, to the same requester, on the next cycle.

Decomposition:
- Package membus_pkg holds:
  - typedef owner_t, enum {OWN_NONE, OWN_I, OWN_D}.
  - Struct types membus_req_t {valid, wen, addr, wdata} and membus_resp_t {rvalid, rdata}, parameterised by package constants for the default widths.
- One sub-module is natural: rr_arbiter2, a 2-input grant generator holding last_q with a ROUND_ROBIN switch. It is reused later for multi-port peripherals.

Test Plan:
- Reset then I only: i_valid=1, i_addr=0x0010 each cycle -> i_ready=1 every cycle; mem_addr=0x0010; i_rvalid=1 one cycle later with mem[0x10]; d_rvalid stays 0.
- Contention, ROUND_ROBIN=1: both valid for 4 cycles, I addr 0x0020, D addr 0x0030 -> grants D, I, D, I; rvalids follow one cycle later with the matching data.
- Contention, ROUND_ROBIN=0: both valid for 3 cycles -> d_ready=1 every cycle, i_ready=0, I stalled with i_addr held; I is granted in the cycle after D drops.
- D write then read: write addr 0x0040 data 0xDEADBEEF, next cycle read 0x0040 -> first d_rvalid returns the old word; second d_rvalid returns 0xDEADBEEF.
- Reset mid-flight: I accepted, rst=0 on the next posedge -> i_rvalid=0 and tag_q=NONE after reset; no spurious rvalid in the following 3 cycles.
- Idle: no valids for 5 cycles -> mem_valid=0, i_rvalid=0, d_rvalid=0, and last_q unchanged.
